seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
Receive-side counterpart to the clock's multiplexed 7-segment display driver. Samples the scanned segment lines and digit-select lines and decodes each segment pattern back to a 4-bit digit code. Assembles the four digits into a frame and publishes the frame once it has been identical for a set number of consecutive scans. Used as an on-chip loopback monitor and by the verification bench to read the displayed time without a display.

Parameters:
SETTLE, 2, cycles the digit select must be unchanged before the segments are sampled (1..255)
MATCH_FRAMES, 2, consecutive identical frames required before publishing (1..15)
SEG_ACTIVE_LOW, 0, 1 = segment lines are active-low; inverted before decode
SEL_ACTIVE_LOW, 0, 1 = digit-select lines are active-low; inverted before decode
TIMEOUT, 1024, scan-loss timeout in cycles (only used with SCAN_TIMEOUT_EN)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
segment  input  7  segment lines, bit0=a .. bit6=g
digit_sel  input  4  digit select, one-hot after polarity fix; bit0 = digit 0
digits  output  16  published frame, {d3,d2,d1,d0}, 4 bits per digit
frame_valid  output  1  one-cycle pulse when digits is updated
stable  output  1  high once any frame has been published
bad_pattern  output  1  one-cycle pulse when a captured pattern does not decode
scan_lost  output  1  level; only present with SCAN_TIMEOUT_EN

Behaviour:
- Reset is synchronous and active-high. It clears all registers: digits=16'h0000, frame_valid=0, stable=0, bad_pattern=0, scan_lost=0, capture mask=0, match count=0, dwell count=0.
- Input stage: segment and digit_sel are registered once (sel_q, seg_q), with the polarity fix applied.
- Dwell:
  - If sel_q is not exactly one-hot (zero bits or several bits set), dwell_cnt=0 and nothing is captured.
  - If sel_q is one-hot and equals its previous value, dwell_cnt increments and saturates at SETTLE.
  - Any change of sel_q resets dwell_cnt to 0.
- Capture:
  - Happens on the cycle dwell_cnt reaches SETTLE, once per dwell.
  - seg_q is decoded and written into frame_buf[idx], and mask[idx] is set.
  - Recapturing an index that is already set overwrites it and does not disturb the mask.
- Decode (gfedcba hex → code):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 00 (blank)→A.
  - Any other pattern → F, and bad_pattern pulses on the cycle after capture.
- Frame complete: when mask becomes 4'b1111, the next cycle does the following.
  - Compare frame_buf to prev_frame.
  - Equal: match_cnt++ (saturating at MATCH_FRAMES). Not equal: match_cnt=1.
  - prev_frame<=frame_buf and mask<=0. A capture arriving in that same cycle sets its mask bit after the clear.
- Publish: on the frame-complete cycle where match_cnt transitions to MATCH_FRAMES:
  - digits<=frame_buf, frame_valid=1 for exactly one cycle, stable<=1.
  - With MATCH_FRAMES=1, every frame that differs from digits is published, plus the first frame after reset.
  - Further identical frames do not pulse frame_valid.
- A differing frame after lock leaves digits held and stable=1 until the new value itself locks.
- Latency: digit_sel change at input → capture at cycle 1+SETTLE (relative to the change) → frame_valid at least 1 cycle after the fourth capture.
- Reset asserted mid-frame discards the partial frame; the bench sees no frame_valid pulse.

Optional Feature:
SCAN_TIMEOUT_EN
- Defined:
  - A counter clears on every capture and increments otherwise.
  - When it reaches TIMEOUT, scan_lost=1, stable=0, mask=0 and match_cnt=0. digits is held.
  - The next capture clears scan_lost, and the next lock re-raises stable.
- Undefined: no counter is built, the scan_lost port is absent, and stable never falls except on reset.

Test Plan:
1. Scan digits 1,2,3,4 (06,5B,4F,66) on sel 0001..1000, 8 cycles each, for 2 frames → frame_valid pulses once, digits=16'h4321, stable=1, bad_pattern never pulses.
2. Continue same scan for 5 more frames → no further frame_valid; change d0 to 7D for 2 frames → one pulse, digits=16'h4326.
3. Glitch: alternate 06/5B frame-to-frame on d0 → match_cnt never reaches 2, digits unchanged, no frame_valid.
4. Pattern 7'h55 on d2 → bad_pattern pulse one cycle after capture; after lock, digits[11:8]=4'hF. sel=0000 or 0011 for 20 cycles → no capture, mask unchanged.
5. SETTLE=2, sel dwell of 2 cycles → no capture; dwell of 3 cycles → capture. Reset asserted after 3 captures → digits=0, mask=0, no frame_valid.
6. (SCAN_TIMEOUT_EN, TIMEOUT=16) locked, then freeze sel at 0000 → scan_lost=1 and stable=0 after 16 cycles with digits held; resume scan → scan_lost=0, stable=1 after 2 frames.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: decodes a scanned 7-segment display back into a 4-digit frame; defining SCAN_TIMEOUT_EN adds scan-loss detection (scan_lost).
// Latency: capture 1+SETTLE cycles after a digit_sel change, publish 1 cycle after the 4th capture; no backpressure, free-running sampler.
module seg_scan_capture #(
    parameter int unsigned SETTLE         = 2,
    parameter int unsigned MATCH_FRAMES   = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          SEL_ACTIVE_LOW = 1'b0,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  segment,
    input  logic [3:0]  digit_sel,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        stable,
`ifdef SCAN_TIMEOUT_EN
    output logic        scan_lost,
`endif
    output logic        bad_pattern
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);
    localparam logic [3:0] MATCH_C  = 4'(MATCH_FRAMES);

    logic [3:0]  sel_q, sel_d, sel_prev_q;
    logic [6:0]  seg_q, seg_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [15:0] frame_buf_q, frame_buf_d;
    logic [15:0] prev_frame_q, prev_frame_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  match_q, match_d;
    logic [15:0] digits_q, digits_d;
    logic        frame_valid_q, frame_valid_d;
    logic        stable_q, stable_d;
    logic        bad_q, bad_d;

    logic        sel_onehot, sel_same, capture;
    logic [3:0]  cap_bits, cap_code;
    logic        frame_done, frame_eq, publish;

    function automatic logic [3:0] decode_seg(input logic [6:0] s);
        logic [3:0] code;
        case (s)
            7'h3F:   code = 4'h0;
            7'h06:   code = 4'h1;
            7'h5B:   code = 4'h2;
            7'h4F:   code = 4'h3;
            7'h66:   code = 4'h4;
            7'h6D:   code = 4'h5;
            7'h7D:   code = 4'h6;
            7'h07:   code = 4'h7;
            7'h7F:   code = 4'h8;
            7'h6F:   code = 4'h9;
            7'h00:   code = 4'hA;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

    assign sel_d = digit_sel ^ {4{SEL_ACTIVE_LOW}};
    assign seg_d = segment ^ {7{SEG_ACTIVE_LOW}};

    assign sel_onehot = $onehot(sel_q);
    assign sel_same   = (sel_q == sel_prev_q);

    // The capture fires on the single cycle the dwell count steps onto SETTLE.
    assign capture  = sel_onehot && sel_same && (dwell_q == SETTLE_C - 8'd1);
    assign cap_code = decode_seg(seg_q);
    assign cap_bits = capture ? sel_q : 4'b0000;

    assign frame_done = (mask_q == 4'hF);
    assign frame_eq   = (frame_buf_q == prev_frame_q);

    always_comb begin
        dwell_d = 8'd0;
        if (sel_onehot && sel_same) begin
            dwell_d = (dwell_q >= SETTLE_C) ? SETTLE_C : dwell_q + 8'd1;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    localparam int TO_BITS = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_BITS-1:0] TO_MAX  = TO_BITS'(TIMEOUT);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    logic [TO_BITS-1:0] to_q, to_d;
    logic               lost_q, lost_d;
    logic               timeout_hit;

    assign timeout_hit = !capture && (to_q == TO_LAST);

    always_comb begin
        to_d   = to_q;
        lost_d = lost_q;
        if (capture) begin
            to_d   = '0;
            lost_d = 1'b0;
        end else begin
            if (to_q != TO_MAX) begin
                to_d = to_q + TO_BITS'(1);
            end
            if (timeout_hit) begin
                lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            to_q   <= '0;
            lost_q <= 1'b0;
        end else begin
            to_q   <= to_d;
            lost_q <= lost_d;
        end
    end

    assign scan_lost = lost_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        frame_buf_d = frame_buf_q;
        for (int i = 0; i < 4; i++) begin
            if (cap_bits[i]) begin
                frame_buf_d[i*4 +: 4] = cap_code;
            end
        end

        // A capture landing on the frame-complete cycle survives the mask clear.
        mask_d       = (frame_done ? 4'b0000 : mask_q) | cap_bits;
        prev_frame_d = frame_done ? frame_buf_q : prev_frame_q;

        match_d = match_q;
        if (frame_done) begin
            if (frame_eq) begin
                match_d = (match_q >= MATCH_C) ? MATCH_C : match_q + 4'd1;
            end else begin
                match_d = 4'd1;
            end
        end

        // The !frame_eq term lets MATCH_FRAMES=1 publish every changed frame.
        publish = frame_done && (match_d == MATCH_C) && ((match_q != MATCH_C) || !frame_eq);

`ifdef SCAN_TIMEOUT_EN
        if (timeout_hit) begin
            mask_d  = 4'b0000;
            match_d = 4'd0;
            publish = 1'b0;
        end
`endif

        digits_d      = publish ? frame_buf_q : digits_q;
        frame_valid_d = publish;
        stable_d      = stable_q | publish;
`ifdef SCAN_TIMEOUT_EN
        if (timeout_hit) begin
            stable_d = 1'b0;
        end
`endif
        bad_d = capture && (cap_code == 4'hF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q         <= 4'b0000;
            sel_prev_q    <= 4'b0000;
            seg_q         <= 7'h00;
            dwell_q       <= 8'd0;
            frame_buf_q   <= 16'h0000;
            prev_frame_q  <= 16'h0000;
            mask_q        <= 4'b0000;
            match_q       <= 4'd0;
            digits_q      <= 16'h0000;
            frame_valid_q <= 1'b0;
            stable_q      <= 1'b0;
            bad_q         <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            sel_prev_q    <= sel_q;
            seg_q         <= seg_d;
            dwell_q       <= dwell_d;
            frame_buf_q   <= frame_buf_d;
            prev_frame_q  <= prev_frame_d;
            mask_q        <= mask_d;
            match_q       <= match_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            stable_q      <= stable_d;
            bad_q         <= bad_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign stable      = stable_q;
    assign bad_pattern = bad_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: random and directed scans checked against a frame-history reference model.
module tb_seg_scan_capture;

    localparam int SETTLE = 2;
    localparam int MF     = 2;
    localparam int TMO    = 16;
`ifdef SCAN_TIMEOUT_EN
    localparam int GAP = 5;
`else
    localparam int GAP = 10;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  segment = 7'h00;
    logic [3:0]  digit_sel = 4'b0000;
    logic [15:0] digits;
    logic        frame_valid, stable, bad_pattern;
`ifdef SCAN_TIMEOUT_EN
    logic        scan_lost;
`endif

    seg_scan_capture #(
        .SETTLE(SETTLE), .MATCH_FRAMES(MF), .SEG_ACTIVE_LOW(1'b0),
        .SEL_ACTIVE_LOW(1'b0), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset), .segment(segment), .digit_sel(digit_sel),
        .digits(digits), .frame_valid(frame_valid), .stable(stable),
`ifdef SCAN_TIMEOUT_EN
        .scan_lost(scan_lost),
`endif
        .bad_pattern(bad_pattern)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int fv_cnt   = 0;
    int bad_cnt  = 0;
    int exp_fv   = 0;
    int exp_bad  = 0;
    logic [15:0] exp_digits = 16'h0000;
    logic        exp_stable = 1'b0;
    logic [15:0] hist[$];
    logic [6:0]  pat_tab[11] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h00};

    localparam logic [27:0] FR_4321 = {7'h66, 7'h4F, 7'h5B, 7'h06};
    localparam logic [27:0] FR_4326 = {7'h66, 7'h4F, 7'h5B, 7'h7D};
    localparam logic [27:0] FR_4322 = {7'h66, 7'h4F, 7'h5B, 7'h5B};

    always @(negedge clock) begin
        if (!reset) begin
            if (frame_valid) fv_cnt++;
            if (bad_pattern) bad_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] ref_code(input logic [6:0] p);
        for (int i = 0; i < 11; i++) begin
            if (pat_tab[i] == p) return 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        digit_sel = 4'b0000;
        segment   = 7'h00;
        tick(n);
    endtask

    task automatic drive_digit(input int idx, input logic [6:0] p, input int dwell);
        digit_sel = 4'(1 << idx);
        segment   = p;
        tick(dwell);
    endtask

    // A frame is published when it closes a run of exactly MF identical frames.
    task automatic model_frame(input logic [15:0] f);
        int run = 0;
        hist.push_back(f);
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == f) run++;
            else break;
        end
        if (run == MF) begin
            exp_fv++;
            exp_digits = f;
            exp_stable = 1'b1;
        end
    endtask

    task automatic scan_frame(input logic [27:0] pats, input int dwell);
        logic [15:0] f;
        for (int d = 0; d < 4; d++) begin
            drive_digit(d, pats[d*7 +: 7], dwell);
            f[d*4 +: 4] = ref_code(pats[d*7 +: 7]);
            if (ref_code(pats[d*7 +: 7]) == 4'hF) exp_bad++;
        end
        model_frame(f);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        digit_sel = 4'b0000;
        segment = 7'h00;
        tick(3);
        reset = 1'b0;
        hist.delete();
        exp_digits = 16'h0000;
        exp_stable = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (digits !== 16'h0000) $display("FAIL reset_digits: got %h want 0000", digits); else n_pass++;
        n_checks++; if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", frame_valid); else n_pass++;
        n_checks++; if (stable !== 1'b0) $display("FAIL reset_stable: got %b want 0", stable); else n_pass++;
        n_checks++; if (bad_pattern !== 1'b0) $display("FAIL reset_bad: got %b want 0", bad_pattern); else n_pass++;
`ifdef SCAN_TIMEOUT_EN
        n_checks++; if (scan_lost !== 1'b0) $display("FAIL reset_lost: got %b want 0", scan_lost); else n_pass++;
`endif
    endtask

    task automatic test_lock();
        scan_frame(FR_4321, 8);
        scan_frame(FR_4321, 8);
        idle(4);
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL lock_fv: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
        n_checks++; if (digits !== exp_digits) $display("FAIL lock_digits: got %h want %h", digits, exp_digits); else n_pass++;
        n_checks++; if (stable !== exp_stable) $display("FAIL lock_stable: got %b want %b", stable, exp_stable); else n_pass++;
        n_checks++; if (bad_cnt !== exp_bad) $display("FAIL lock_bad: got %0d want %0d", bad_cnt, exp_bad); else n_pass++;
    endtask

    task automatic test_hold_change();
        for (int i = 0; i < 5; i++) scan_frame(FR_4321, 8);
        idle(4);
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL hold_fv: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
        scan_frame(FR_4326, 8);
        idle(4);
        n_checks++; if (digits !== exp_digits) $display("FAIL change_held: got %h want %h", digits, exp_digits); else n_pass++;
        scan_frame(FR_4326, 8);
        idle(4);
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL change_fv: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
        n_checks++; if (digits !== exp_digits) $display("FAIL change_digits: got %h want %h", digits, exp_digits); else n_pass++;
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 6; i++) scan_frame((i % 2 == 0) ? FR_4321 : FR_4322, 8);
        idle(4);
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL glitch_fv: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
        n_checks++; if (digits !== exp_digits) $display("FAIL glitch_digits: got %h want %h", digits, exp_digits); else n_pass++;
    endtask

    task automatic test_bad();
        logic [15:0] f;
        f = {ref_code(7'h66), ref_code(7'h55), ref_code(7'h5B), ref_code(7'h06)};
        for (int fr = 0; fr < 2; fr++) begin
            drive_digit(0, 7'h06, 8);
            drive_digit(1, 7'h5B, 4);
            digit_sel = 4'b0000; segment = 7'h55; tick(GAP);
            digit_sel = 4'b0011; segment = 7'h55; tick(GAP);
            digit_sel = 4'b0100; segment = 7'h55;
            tick(3);
            n_checks++; if (bad_pattern !== 1'b0) $display("FAIL bad_early: got %b want 0", bad_pattern); else n_pass++;
            tick(1);
            n_checks++; if (bad_pattern !== 1'b1) $display("FAIL bad_pulse: got %b want 1", bad_pattern); else n_pass++;
            tick(1);
            n_checks++; if (bad_pattern !== 1'b0) $display("FAIL bad_late: got %b want 0", bad_pattern); else n_pass++;
            tick(3);
            drive_digit(3, 7'h66, 8);
            exp_bad++;
            model_frame(f);
        end
        idle(4);
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL bad_fv: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
        n_checks++; if (digits !== exp_digits) $display("FAIL bad_digits: got %h want %h", digits, exp_digits); else n_pass++;
        n_checks++; if (digits[11:8] !== 4'hF) $display("FAIL bad_d2: got %h want f", digits[11:8]); else n_pass++;
        n_checks++; if (bad_cnt !== exp_bad) $display("FAIL bad_count: got %0d want %0d", bad_cnt, exp_bad); else n_pass++;
    endtask

    task automatic test_dwell();
        drive_digit(0, 7'h06, 8);
        drive_digit(1, 7'h55, 2);
        drive_digit(2, 7'h4F, 8);
        drive_digit(3, 7'h66, 8);
        n_checks++; if (bad_cnt !== exp_bad) $display("FAIL dwell2_capture: bad count got %0d want %0d", bad_cnt, exp_bad); else n_pass++;
        drive_digit(1, 7'h5B, 3);
        model_frame(16'h4321);
        idle(4);
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL dwell3_first_fv: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
        scan_frame(FR_4321, 3);
        idle(4);
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL dwell3_fv: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
        n_checks++; if (digits !== exp_digits) $display("FAIL dwell3_digits: got %h want %h", digits, exp_digits); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive_digit(0, 7'h7D, 8);
        drive_digit(1, 7'h5B, 8);
        drive_digit(2, 7'h4F, 8);
        do_reset();
        n_checks++; if (digits !== exp_digits) $display("FAIL rmid_digits: got %h want %h", digits, exp_digits); else n_pass++;
        n_checks++; if (stable !== exp_stable) $display("FAIL rmid_stable: got %b want %b", stable, exp_stable); else n_pass++;
        scan_frame(FR_4321, 8);
        idle(4);
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL rmid_fv1: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
        scan_frame(FR_4321, 8);
        idle(4);
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL rmid_fv2: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
        n_checks++; if (digits !== exp_digits) $display("FAIL rmid_digits2: got %h want %h", digits, exp_digits); else n_pass++;
    endtask

    task automatic test_random();
        logic [27:0] cands[3];
        int cur = 0;
        cands[0] = FR_4321;
        cands[1] = {7'h66, 7'h7F, 7'h5B, 7'h06};
        cands[2] = {7'h55, 7'h4F, 7'h5B, 7'h3F};
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 0) cur = int'($urandom_range(0, 2));
            scan_frame(cands[cur], int'($urandom_range(3, 6)));
            idle(4 + int'($urandom_range(0, 2)));
            n_checks++; if (fv_cnt !== exp_fv) $display("FAIL rand_fv[%0d]: got %0d want %0d", n, fv_cnt, exp_fv); else n_pass++;
            n_checks++; if (digits !== exp_digits) $display("FAIL rand_digits[%0d]: got %h want %h", n, digits, exp_digits); else n_pass++;
        end
        n_checks++; if (bad_cnt !== exp_bad) $display("FAIL rand_bad: got %0d want %0d", bad_cnt, exp_bad); else n_pass++;
    endtask

`ifdef SCAN_TIMEOUT_EN
    task automatic test_timeout();
        scan_frame(FR_4321, 8);
        scan_frame(FR_4321, 8);
        idle(4);
        n_checks++; if (scan_lost !== 1'b0) $display("FAIL to_pre_lost: got %b want 0", scan_lost); else n_pass++;
        idle(30);
        hist.delete();
        exp_stable = 1'b0;
        n_checks++; if (scan_lost !== 1'b1) $display("FAIL to_lost: got %b want 1", scan_lost); else n_pass++;
        n_checks++; if (stable !== exp_stable) $display("FAIL to_stable: got %b want %b", stable, exp_stable); else n_pass++;
        n_checks++; if (digits !== exp_digits) $display("FAIL to_digits: got %h want %h", digits, exp_digits); else n_pass++;
        scan_frame(FR_4321, 8);
        idle(4);
        n_checks++; if (scan_lost !== 1'b0) $display("FAIL to_resume_lost: got %b want 0", scan_lost); else n_pass++;
        n_checks++; if (stable !== exp_stable) $display("FAIL to_resume_stable1: got %b want %b", stable, exp_stable); else n_pass++;
        scan_frame(FR_4321, 8);
        idle(4);
        n_checks++; if (stable !== exp_stable) $display("FAIL to_resume_stable2: got %b want %b", stable, exp_stable); else n_pass++;
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL to_resume_fv: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
    endtask
`else
    task automatic test_no_timeout();
        idle(40);
        n_checks++; if (stable !== exp_stable) $display("FAIL idle_stable: got %b want %b", stable, exp_stable); else n_pass++;
        n_checks++; if (digits !== exp_digits) $display("FAIL idle_digits: got %h want %h", digits, exp_digits); else n_pass++;
        n_checks++; if (fv_cnt !== exp_fv) $display("FAIL idle_fv: got %0d want %0d", fv_cnt, exp_fv); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_hold_change();
        test_glitch();
        test_bad();
        test_dwell();
        test_reset_mid();
        test_random();
`ifdef SCAN_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
